alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_sched_pkg.sv | 56 +++++
 rtl/alu_sched_if.sv | 63 ++++++
 rtl/alu_rr_arb.sv | 21 ++
 rtl/alu_sched.sv | 136 +++++++++++++
 tb/tb_alu_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - opcodes, FSM states and flag layout shared by the ALU scheduler
package alu_sched_pkg;

    // 4-bit operation codes presented to the shared ALU
    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_XOR  = 4'b0010,
        OP_NOT  = 4'b0011,
        OP_ADDU = 4'b0100,
        OP_SUBU = 4'b0101,
        OP_ADDS = 4'b0110,
        OP_SUBS = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001
    } opcode_t;

    // Scheduler states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Bit positions inside the 4-bit {carry,negative,overflow,zero} flag word
    localparam int FLAG_ZERO     = 0;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_NEGATIVE = 2;
    localparam int FLAG_CARRY    = 3;

    // Carry only means something for unsigned add/sub and right shift
    function automatic logic op_has_carry(input logic [3:0] op);
        return (op == OP_ADDU) || (op == OP_SUBU) || (op == OP_SRL);
    endfunction

    // Negative/overflow only mean something for signed add/sub
    function automatic logic op_has_nv(input logic [3:0] op);
        return (op == OP_ADDS) || (op == OP_SUBS);
    endfunction

    // Build the flag word captured at the end of EXEC; zero is always local
    function automatic logic [3:0] capture_flags(input logic [3:0]  op,
                                                 input logic [31:0] result,
                                                 input logic        carry,
                                                 input logic        negative,
                                                 input logic        overflow);
        logic [3:0] f;
        f                = 4'b0000;
        f[FLAG_ZERO]     = (result == 32'd0);
        f[FLAG_CARRY]    = op_has_carry(op) & carry;
        f[FLAG_NEGATIVE] = op_has_nv(op) & negative;
        f[FLAG_OVERFLOW] = op_has_nv(op) & overflow;
        return f;
    endfunction

endpackage

// File: rtl/alu_sched_if.sv
// rtl/alu_sched_if.sv - request/response channels, ALU drive/return and status bundle
interface alu_sched_if;

    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;

    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_result;
    logic [3:0]  rsp0_flags;

    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_result;
    logic [3:0]  rsp1_flags;

    logic [3:0]  alu_operation;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic        alu_negative;
    logic        alu_overflow;

    logic        busy;
    logic [15:0] op_count;

    // Scheduler side
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        input  alu_result, alu_carry, alu_negative, alu_overflow,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_flags,
        output rsp1_valid, rsp1_result, rsp1_flags,
        output alu_operation, alu_a, alu_b,
        output busy, op_count
    );

    // Requester / ALU side
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        output alu_result, alu_carry, alu_negative, alu_overflow,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_flags,
        input  rsp1_valid, rsp1_result, rsp1_flags,
        input  alu_operation, alu_a, alu_b,
        input  busy, op_count
    );

endinterface

// File: rtl/alu_rr_arb.sv
// rtl/alu_rr_arb.sv - two-requester round-robin grant selection
module alu_rr_arb (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic grant_valid_o,
    output logic grant_id_o
);

    // A lone requester wins outright; on a tie the port not served last wins
    always_comb begin
        grant_valid_o = req0_i | req1_i;
        grant_id_o    = 1'b0;
        if (req0_i && req1_i) begin
            grant_id_o = ~last_grant_i;
        end else if (req1_i) begin
            grant_id_o = 1'b1;
        end
    end

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - two-port scheduler sharing one combinational ALU
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    alu_sched_if.slave bus
);

    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 4)) begin : g_bad_settle
        $error("alu_sched: SETTLE_CYCLES must be within 1..4");
    end

    localparam logic [1:0] SETTLE_INIT = 2'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        gnt_id_q, gnt_id_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic [3:0]  flags_q, flags_d;
    logic [15:0] op_count_q, op_count_d;

    logic        arb_valid;
    logic        arb_id;
    logic        rsp_hs;
    logic [3:0]  cap_flags;

    alu_rr_arb u_arb (
        .req0_i        (bus.req0_valid),
        .req1_i        (bus.req1_valid),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (arb_valid),
        .grant_id_o    (arb_id)
    );

    assign rsp_hs    = (state_q == ST_RESP) && (gnt_id_q ? bus.rsp1_ready : bus.rsp0_ready);
    assign cap_flags = capture_flags(op_q, bus.alu_result, bus.alu_carry,
                                     bus.alu_negative, bus.alu_overflow);

    // Next-state: accept in IDLE, count down the settle window, wait for the handshake
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        flags_d      = flags_q;
        op_count_d   = op_count_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_id_d = arb_id;
                    op_d     = arb_id ? bus.req1_op : bus.req0_op;
                    a_d      = arb_id ? bus.req1_a  : bus.req0_a;
                    b_d      = arb_id ? bus.req1_b  : bus.req0_b;
                    cnt_d    = SETTLE_INIT;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 2'd0) begin
                    result_d = bus.alu_result;
                    flags_d  = cap_flags;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_RESP: begin
                // Returning to IDLE here means no new request is taken this cycle
                if (rsp_hs) begin
                    state_d      = ST_IDLE;
                    op_count_d   = op_count_q + 16'd1;
                    last_grant_d = gnt_id_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight op silently
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            gnt_id_q     <= 1'b0;
            op_q         <= 4'd0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            cnt_q        <= 2'd0;
            result_q     <= 32'd0;
            flags_q      <= 4'd0;
            op_count_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            op_count_q   <= op_count_d;
        end
    end

    assign bus.req0_ready    = (state_q == ST_IDLE);
    assign bus.req1_ready    = (state_q == ST_IDLE);

    assign bus.rsp0_valid    = (state_q == ST_RESP) && !gnt_id_q;
    assign bus.rsp1_valid    = (state_q == ST_RESP) &&  gnt_id_q;
    assign bus.rsp0_result   = gnt_id_q ? 32'd0 : result_q;
    assign bus.rsp1_result   = gnt_id_q ? result_q : 32'd0;
    assign bus.rsp0_flags    = gnt_id_q ? 4'd0 : flags_q;
    assign bus.rsp1_flags    = gnt_id_q ? flags_q : 4'd0;

    assign bus.alu_operation = op_q;
    assign bus.alu_a         = a_q;
    assign bus.alu_b         = b_q;

    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.op_count      = op_count_q;

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - self-checking bench for alu_sched at SETTLE_CYCLES 1 and 3
module tb_alu_sched;

    logic clk;
    logic rst [2];

    logic        drv_valid  [2][2];
    logic [3:0]  drv_op     [2][2];
    logic [31:0] drv_a      [2][2];
    logic [31:0] drv_b      [2][2];
    logic        drv_rready [2][2];

    logic        obs_req_ready [2][2];
    logic        obs_rsp_valid [2][2];
    logic [31:0] obs_result    [2][2];
    logic [3:0]  obs_flags     [2][2];
    logic        obs_busy      [2];
    logic [15:0] obs_opcnt     [2];
    logic [3:0]  obs_alu_op    [2];
    logic [31:0] obs_alu_a     [2];
    logic [31:0] obs_alu_b     [2];

    int n_checks;
    int n_errors;
    int m_cnt  [2];
    bit m_last [2];

    // External ALU: {carry,negative,overflow,result}; unused flag lines carry noise
    function automatic logic [34:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic c, n, v;
        int sh;
        w  = {1'b0, a} + {1'b0, b};
        sh = int'(b[4:0]);
        case (op)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a ^ b;
            4'd3:    r = ~a;
            4'd4:    r = w[31:0];
            4'd5:    r = a - b;
            4'd6:    r = a + b;
            4'd7:    r = a - b;
            4'd8:    r = a << sh;
            4'd9:    r = a >> sh;
            default: r = a ^ {b[15:0], b[31:16]};
        endcase
        c = r[0] ^ a[7];
        n = r[31];
        v = b[2] ^ a[30];
        case (op)
            4'd4: c = w[32];
            4'd5: c = (a < b);
            4'd6: v = (a[31] == b[31]) && (r[31] != a[31]);
            4'd7: v = (a[31] != b[31]) && (r[31] != a[31]);
            4'd9: c = (sh != 0) ? a[sh-1] : 1'b0;
            default: ;
        endcase
        return {c, n, v, r};
    endfunction

    // Flags the scheduler must report for an op given the ALU's raw outputs
    function automatic logic [3:0] ref_flags(input logic [3:0] op, input logic [34:0] alu);
        logic c, n, v, z;
        c = alu[34];
        n = alu[33];
        v = alu[32];
        z = (alu[31:0] == 32'd0);
        if (!(op inside {4'b0100, 4'b0101, 4'b1001})) c = 1'b0;
        if (!(op inside {4'b0110, 4'b0111})) begin
            n = 1'b0;
            v = 1'b0;
        end
        return {c, n, v, z};
    endfunction

    alu_sched_if bus [2] ();

    for (genvar d = 0; d < 2; d++) begin : g_dut
        assign bus[d].req0_valid = drv_valid[d][0];
        assign bus[d].req0_op    = drv_op[d][0];
        assign bus[d].req0_a     = drv_a[d][0];
        assign bus[d].req0_b     = drv_b[d][0];
        assign bus[d].req1_valid = drv_valid[d][1];
        assign bus[d].req1_op    = drv_op[d][1];
        assign bus[d].req1_a     = drv_a[d][1];
        assign bus[d].req1_b     = drv_b[d][1];
        assign bus[d].rsp0_ready = drv_rready[d][0];
        assign bus[d].rsp1_ready = drv_rready[d][1];
        assign {bus[d].alu_carry, bus[d].alu_negative, bus[d].alu_overflow, bus[d].alu_result} =
            alu_model(bus[d].alu_operation, bus[d].alu_a, bus[d].alu_b);

        assign obs_req_ready[d][0] = bus[d].req0_ready;
        assign obs_req_ready[d][1] = bus[d].req1_ready;
        assign obs_rsp_valid[d][0] = bus[d].rsp0_valid;
        assign obs_rsp_valid[d][1] = bus[d].rsp1_valid;
        assign obs_result[d][0]    = bus[d].rsp0_result;
        assign obs_result[d][1]    = bus[d].rsp1_result;
        assign obs_flags[d][0]     = bus[d].rsp0_flags;
        assign obs_flags[d][1]     = bus[d].rsp1_flags;
        assign obs_busy[d]         = bus[d].busy;
        assign obs_opcnt[d]        = bus[d].op_count;
        assign obs_alu_op[d]       = bus[d].alu_operation;
        assign obs_alu_a[d]        = bus[d].alu_a;
        assign obs_alu_b[d]        = bus[d].alu_b;

        alu_sched #(.SETTLE_CYCLES(d == 0 ? 1 : 3)) u_dut (
            .clk   (clk),
            .reset (rst[d]),
            .bus   (bus[d])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic idle_checks(input int d, input string tag);
        chk({tag, "_busy"},   obs_busy[d], 0);
        chk({tag, "_rdy0"},   obs_req_ready[d][0], 1);
        chk({tag, "_rdy1"},   obs_req_ready[d][1], 1);
        chk({tag, "_rspv0"},  obs_rsp_valid[d][0], 0);
        chk({tag, "_rspv1"},  obs_rsp_valid[d][1], 0);
        chk({tag, "_opcnt"},  obs_opcnt[d], 32'(m_cnt[d] % 65536));
    endtask

    // Called away from a rising edge with the DUT idle; returns at a falling edge
    task automatic do_reset(input int d);
        drv_valid[d][0] = 0; drv_valid[d][1] = 0;
        rst[d] = 1'b1;
        @(posedge clk); #1;
        rst[d] = 1'b0;
        m_cnt[d]  = 0;
        m_last[d] = 1'b1;
        @(negedge clk);
    endtask

    // One scheduled op end to end; gid/res/flg are what the DUT actually presented
    task automatic run_op(input int d, input bit v0, input bit v1,
                          input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                          input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                          input int rdy_delay,
                          output logic gid, output logic [31:0] res, output logic [3:0] flg);
        bit          g;
        logic [3:0]  gop;
        logic [31:0] ga, gb, exp_res;
        logic [3:0]  exp_flg;
        logic [34:0] alu;
        int          s;
        s       = (d == 0) ? 1 : 3;
        g       = (v0 && v1) ? !m_last[d] : v1;
        gop     = g ? op1 : op0;
        ga      = g ? a1 : a0;
        gb      = g ? b1 : b0;
        alu     = alu_model(gop, ga, gb);
        exp_res = alu[31:0];
        exp_flg = ref_flags(gop, alu);

        drv_valid[d][0] = v0; drv_op[d][0] = op0; drv_a[d][0] = a0; drv_b[d][0] = b0;
        drv_valid[d][1] = v1; drv_op[d][1] = op1; drv_a[d][1] = a1; drv_b[d][1] = b1;
        drv_rready[d][g]  = (rdy_delay == 0);
        drv_rready[d][!g] = 1'($urandom_range(0, 1));
        #1;
        idle_checks(d, "pre");

        @(posedge clk); #1;
        for (int p = 0; p < 2; p++) begin
            drv_op[d][p] = 4'($urandom);
            drv_a[d][p]  = $urandom;
            drv_b[d][p]  = $urandom;
        end
        for (int j = 0; j < s; j++) begin
            @(negedge clk);
            chk("exec_rspv",  obs_rsp_valid[d][g], 0);
            chk("exec_busy",  obs_busy[d], 1);
            chk("exec_rdy0",  obs_req_ready[d][0], 0);
            chk("exec_rdy1",  obs_req_ready[d][1], 0);
            chk("exec_aluop", obs_alu_op[d], gop);
            chk("exec_alua",  obs_alu_a[d], ga);
            chk("exec_alub",  obs_alu_b[d], gb);
            @(posedge clk);
        end
        @(negedge clk);
        gid = obs_rsp_valid[d][1];
        res = obs_result[d][g];
        flg = obs_flags[d][g];
        for (int c = 0; c <= rdy_delay; c++) begin
            chk("resp_valid",   obs_rsp_valid[d][g], 1);
            chk("resp_ovalid",  obs_rsp_valid[d][!g], 0);
            chk("resp_result",  obs_result[d][g], exp_res);
            chk("resp_flags",   obs_flags[d][g], exp_flg);
            chk("resp_oresult", obs_result[d][!g], 0);
            chk("resp_oflags",  obs_flags[d][!g], 0);
            chk("resp_rdy0",    obs_req_ready[d][0], 0);
            chk("resp_rdy1",    obs_req_ready[d][1], 0);
            chk("resp_opcnt",   obs_opcnt[d], 32'(m_cnt[d] % 65536));
            if (c < rdy_delay) begin
                @(posedge clk); #1;
                if (c == rdy_delay - 1) drv_rready[d][g] = 1'b1;
                @(negedge clk);
            end
        end
        @(posedge clk); #1;
        drv_rready[d][0] = 0; drv_rready[d][1] = 0;
        m_cnt[d]++;
        m_last[d] = g;
        @(negedge clk);
        idle_checks(d, "post");
        drv_valid[d][0] = 0; drv_valid[d][1] = 0;
    endtask

    task automatic reset_in_exec(input int d);
        drv_valid[d][0] = 1; drv_op[d][0] = 4'b0110; drv_a[d][0] = 32'h1234_5678; drv_b[d][0] = 32'h1;
        drv_valid[d][1] = 0;
        drv_rready[d][0] = 1; drv_rready[d][1] = 1;
        #1;
        chk("rexec_rdy", obs_req_ready[d][0], 1);
        @(posedge clk); #1;
        drv_valid[d][0] = 0;
        rst[d] = 1'b1;
        @(negedge clk);
        chk("rexec_busy_before", obs_busy[d], 1);
        @(posedge clk); #1;
        rst[d] = 1'b0;
        m_cnt[d]  = 0;
        m_last[d] = 1'b1;
        @(negedge clk);
        idle_checks(d, "rexec");
        chk("rexec_alua", obs_alu_a[d], 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rexec_norsp0", obs_rsp_valid[d][0], 0);
            chk("rexec_norsp1", obs_rsp_valid[d][1], 0);
        end
        drv_rready[d][0] = 0; drv_rready[d][1] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        gid;
        logic [31:0] res;
        logic [3:0]  flg;
        n_checks = 0;
        n_errors = 0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            m_cnt[d] = 0;
            m_last[d] = 1'b1;
            for (int p = 0; p < 2; p++) begin
                drv_valid[d][p] = 0; drv_op[d][p] = 0; drv_a[d][p] = 0;
                drv_b[d][p] = 0; drv_rready[d][p] = 0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            idle_checks(d, "reset");
            chk("reset_aluop", obs_alu_op[d], 0);
            chk("reset_alua",  obs_alu_a[d], 0);
            chk("reset_alub",  obs_alu_b[d], 0);
            chk("reset_res0",  obs_result[d][0], 0);
            chk("reset_res1",  obs_result[d][1], 0);
            chk("reset_flg0",  obs_flags[d][0], 0);
            chk("reset_flg1",  obs_flags[d][1], 0);
        end

        run_op(0, 1, 0, 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd0, 32'd0, 32'd0, 0, gid, res, flg);
        chk("and_result", res, 32'hF000_F000);
        chk("and_flags",  flg, 4'b0000);

        run_op(0, 0, 1, 4'd0, 32'd0, 32'd0, 4'b0110, 32'h7FFF_FFFF, 32'h0000_0001, 1, gid, res, flg);
        chk("adds_gid",    gid, 1);
        chk("adds_result", res, 32'h8000_0000);
        chk("adds_flags",  flg, 4'b0110);

        run_op(1, 1, 0, 4'b0101, 32'd0, 32'd1, 4'd0, 32'd0, 32'd0, 0, gid, res, flg);
        chk("subu_result", res, 32'hFFFF_FFFF);
        chk("subu_flags",  flg, 4'b1000);

        run_op(0, 0, 1, 4'b0010, 32'hAAAA_5555, 32'hAAAA_5555, 4'b0010, 32'h1357_9BDF, 32'h1357_9BDF,
               5, gid, res, flg);
        chk("stall_result", res, 32'h0000_0000);
        chk("stall_flags",  flg, 4'b0001);

        do_reset(0);
        for (int i = 0; i < 4; i++) begin
            run_op(0, 1, 1, 4'($urandom), $urandom, $urandom, 4'($urandom), $urandom, $urandom,
                   0, gid, res, flg);
            chk("rr_order", gid, 32'(i % 2));
        end
        chk("rr_opcount", obs_opcnt[0], 4);

        for (int i = 0; i < 60; i++) begin
            int d;
            int vp;
            d  = (i % 3 == 2) ? 1 : 0;
            vp = $urandom_range(1, 3);
            run_op(d, vp[0], vp[1], 4'($urandom), pick_val(), pick_val(),
                   4'($urandom), pick_val(), pick_val(), $urandom_range(0, 3), gid, res, flg);
        end

        reset_in_exec(1);
        reset_in_exec(0);
        run_op(0, 1, 1, 4'b0001, 32'h0, 32'h0, 4'b0001, 32'h1, 32'h2, 0, gid, res, flg);
        chk("post_reset_gid",   gid, 0);
        chk("post_reset_zero",  flg, 4'b0001);
        chk("post_reset_count", obs_opcnt[0], 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
